// File: rtl/block_lock_66b.sv
// Purpose : 10GBASE-R sync-header block lock; requests bit-slips until 64b/66b framing is found.
// Latency : dout/hdr_out/dout_even/dout_en are one cycle behind din/hdr_in/even_in/en_in.
// Backpress: none; en_in=0 cycles stall the counters and forward nothing (dout_en=0).
//
// Ports:
//   clk, rst             receive word clock, asynchronous active-low reset
//   din, hdr_in          gearbox word and sync header (header meaningful in a header slot)
//   en_in, even_in       word valid / first word of a block; header slot = en_in & even_in
//   dout, hdr_out        registered word and the header of the block it belongs to
//   dout_en, dout_even   registered (en_in & block_lock) and registered even_in
//   block_lock, slip     lock status, one-cycle bit-slip request to the transceiver
//   sh_invalid_cnt       invalid headers seen in the current test window
module block_lock_66b #(
    parameter int SH_WINDOW      = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [1:0]  hdr_in,
    input  logic        en_in,
    input  logic        even_in,
    output logic [31:0] dout,
    output logic [1:0]  hdr_out,
    output logic        dout_en,
    output logic        dout_even,
    output logic        block_lock,
    output logic        slip,
    output logic [4:0]  sh_invalid_cnt
);

    localparam logic [6:0] WIN_END = 7'(SH_WINDOW);
    localparam logic [4:0] INV_MAX = 5'(SH_INVALID_MAX);
    localparam logic [5:0] WAIT_N  = 6'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_RESET_CNT,
        ST_TEST_SH,
        ST_SLIP,
        ST_SLIP_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] sh_cnt_q, sh_cnt_d;
    logic [4:0] inv_cnt_q, inv_cnt_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       lock_d;
    logic       slip_d;

    logic       hs;
    logic       hdr_ok;
    logic [6:0] sh_base;
    logic [4:0] inv_base;
    logic [6:0] sh_inc;
    logic [4:0] inv_inc;
    logic [5:0] wait_inc;

    assign hs     = en_in & even_in;
    assign hdr_ok = hdr_in[1] ^ hdr_in[0];

    // RESET_CNT clears the counters without spending a cycle: an HS arriving
    // while in RESET_CNT is evaluated against zeroed counters, exactly as the
    // first HS of a fresh TEST_SH window.
    assign sh_base  = (state_q == ST_RESET_CNT) ? 7'd0 : sh_cnt_q;
    assign inv_base = (state_q == ST_RESET_CNT) ? 5'd0 : inv_cnt_q;
    assign sh_inc   = sh_base + 7'd1;
    assign inv_inc  = hdr_ok ? inv_base
                    : ((inv_base == 5'd31) ? 5'd31 : inv_base + 5'd1);
    assign wait_inc = wait_cnt_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = block_lock;
        slip_d     = 1'b0;
        case (state_q)
            ST_RESET_CNT, ST_TEST_SH: begin
                state_d   = ST_TEST_SH;
                sh_cnt_d  = sh_base;
                inv_cnt_d = inv_base;
                if (hs) begin
                    sh_cnt_d  = sh_inc;
                    inv_cnt_d = inv_inc;
                    // Slip wins over a window end that coincides with it.
                    if (!hdr_ok && (!block_lock || inv_inc >= INV_MAX)) begin
                        state_d = ST_SLIP;
                        slip_d  = 1'b1;
                        lock_d  = 1'b0;
                    end else if (sh_inc == WIN_END) begin
                        state_d = ST_RESET_CNT;
                        if (inv_inc == 5'd0) begin
                            lock_d = 1'b1;
                        end
                    end
                end
            end
            ST_SLIP: begin
                wait_cnt_d = 6'd0;
                state_d    = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                // Headers are meaningless while the transceiver realigns.
                if (hs) begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_N) begin
                        state_d = ST_RESET_CNT;
                    end
                end
            end
            default: state_d = ST_RESET_CNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RESET_CNT;
            sh_cnt_q   <= 7'd0;
            inv_cnt_q  <= 5'd0;
            wait_cnt_q <= 6'd0;
            block_lock <= 1'b0;
            slip       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            block_lock <= lock_d;
            slip       <= slip_d;
        end
    end

    assign sh_invalid_cnt = inv_cnt_q;

    // Datapath: dout_en uses the lock value before this cycle's update, so the
    // block that triggers a slip is still forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout      <= 32'd0;
            hdr_out   <= 2'd0;
            dout_en   <= 1'b0;
            dout_even <= 1'b0;
        end else begin
            dout_en <= en_in & block_lock;
            if (en_in) begin
                dout      <= din;
                dout_even <= even_in;
                if (even_in) begin
                    hdr_out <= hdr_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_lock_66b.sv
// Purpose : directed bench for block_lock_66b with a data scoreboard.
// Latency : expects every enabled word on dout one cycle later.
// Backpress: drives en_in idle gaps; the DUT has no ready to honour.
module tb_block_lock_66b;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [1:0]  hdr_in;
    logic        en_in;
    logic        even_in;
    logic [31:0] dout;
    logic [1:0]  hdr_out;
    logic        dout_en;
    logic        dout_even;
    logic        block_lock;
    logic        slip;
    logic [4:0]  sh_invalid_cnt;

    block_lock_66b dut (
        .clk            (clk),
        .rst            (rst),
        .din            (din),
        .hdr_in         (hdr_in),
        .en_in          (en_in),
        .even_in        (even_in),
        .dout           (dout),
        .hdr_out        (hdr_out),
        .dout_en        (dout_en),
        .dout_even      (dout_even),
        .block_lock     (block_lock),
        .slip           (slip),
        .sh_invalid_cnt (sh_invalid_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic [1:0]  h;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_hdr = 2'b00;
    int         n_assert = 0;
    int         n_fail = 0;
    int         slip_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, push expectation, clock, sample #1 later, pop/compare.
    task automatic step(input logic en, input logic ev, input logic [1:0] h, input logic [31:0] d);
        exp_t e;
        en_in   = en;
        even_in = ev;
        hdr_in  = h;
        din     = d;
        if (en) begin
            if (ev) exp_hdr = h;
            sb.push_back({d, ev, exp_hdr});
        end
        @(posedge clk);
        #1;
        if (slip) slip_seen++;
        if (en) begin
            e = sb.pop_front();
            chk("dout", dout, e.d);
            chk("dout_even", 32'(dout_even), 32'(e.e));
            chk("hdr_out", 32'(hdr_out), 32'(e.h));
        end
    endtask

    // Back-to-back block: header word then odd word with a garbage header.
    task automatic blk(input logic [1:0] h);
        step(1'b1, 1'b1, h, $urandom);
        step(1'b1, 1'b0, 2'($urandom), $urandom);
    endtask

    // Sparse block: idle gaps (with even_in=1 and bad headers) around each word.
    task automatic blk_sparse(input logic [1:0] h);
        step(1'b1, 1'b1, h, $urandom);
        step(1'b0, 1'b1, 2'b00, $urandom);
        step(1'b1, 1'b0, 2'b11, $urandom);
        step(1'b0, 1'b1, 2'b11, $urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, dout, 32'd0);
        chk({tag, "_hdr_out"}, 32'(hdr_out), 32'd0);
        chk({tag, "_dout_en"}, 32'(dout_en), 32'd0);
        chk({tag, "_dout_even"}, 32'(dout_even), 32'd0);
        chk({tag, "_block_lock"}, 32'(block_lock), 32'd0);
        chk({tag, "_slip"}, 32'(slip), 32'd0);
        chk({tag, "_inv_cnt"}, 32'(sh_invalid_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; din = 32'd0; hdr_in = 2'b00; en_in = 1'b0; even_in = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Acquire lock with 64 clean headers.
        repeat (63) blk(2'b01);
        chk("lock_after_63", 32'(block_lock), 32'd0);
        step(1'b1, 1'b1, 2'b01, $urandom);
        chk("lock_after_64", 32'(block_lock), 32'd1);
        chk("dout_en_prelock", 32'(dout_en), 32'd0);
        chk("no_slip_acquire", 32'(slip_seen), 32'd0);
        step(1'b1, 1'b0, 2'b11, $urandom);
        chk("dout_en_locked", 32'(dout_en), 32'd1);

        // Locked window with 15 invalid headers: lock held, count then cleared.
        for (int i = 0; i < 63; i++) blk((i < 15) ? 2'b11 : 2'b01);
        chk("inv15_mid", 32'(sh_invalid_cnt), 32'd15);
        step(1'b1, 1'b1, 2'b01, $urandom);
        chk("inv15_window_end", 32'(sh_invalid_cnt), 32'd15);
        chk("inv15_lock", 32'(block_lock), 32'd1);
        step(1'b1, 1'b0, 2'b00, $urandom);
        chk("inv15_cleared", 32'(sh_invalid_cnt), 32'd0);
        chk("inv15_no_slip", 32'(slip_seen), 32'd0);

        // 16 invalid headers in a locked window: loss of lock.
        repeat (15) blk(2'b11);
        chk("inv16_pre_lock", 32'(block_lock), 32'd1);
        chk("inv16_pre_slip", 32'(slip_seen), 32'd0);
        step(1'b1, 1'b1, 2'b11, $urandom);
        chk("inv16_slip", 32'(slip), 32'd1);
        chk("inv16_lock", 32'(block_lock), 32'd0);
        chk("inv16_fwd", 32'(dout_en), 32'd1);
        chk("inv16_cnt", 32'(sh_invalid_cnt), 32'd16);
        step(1'b1, 1'b0, 2'b00, $urandom);
        chk("inv16_slip_1cyc", 32'(slip), 32'd0);
        chk("inv16_dout_en_off", 32'(dout_en), 32'd0);

        // Slip wait ignores 32 invalid headers; 33rd HS is a fresh test.
        repeat (32) blk(2'b11);
        chk("wait_no_reslip", 32'(slip_seen), 32'd1);
        chk("wait_dout_en", 32'(dout_en), 32'd0);
        step(1'b1, 1'b1, 2'b00, $urandom);
        chk("hs33_slip", 32'(slip), 32'd1);
        chk("hs33_slip_cnt", 32'(slip_seen), 32'd2);
        step(1'b1, 1'b0, 2'b01, $urandom);

        // Relock after the wait.
        repeat (32) blk(2'b01);
        repeat (63) blk(2'b01);
        chk("relock_63", 32'(block_lock), 32'd0);
        step(1'b1, 1'b1, 2'b01, $urandom);
        chk("relock_64", 32'(block_lock), 32'd1);
        step(1'b1, 1'b0, 2'b10, $urandom);

        // Asynchronous reset mid-window while locked.
        repeat (20) blk(2'b10);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        en_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_hdr = 2'b00;

        // Unlocked, first HS invalid: immediate slip, then 32 ignored HSs.
        step(1'b1, 1'b1, 2'b00, $urandom);
        chk("first_hs_slip", 32'(slip), 32'd1);
        chk("first_hs_lock", 32'(block_lock), 32'd0);
        step(1'b1, 1'b0, 2'b00, $urandom);
        repeat (32) blk(2'b00);
        chk("wait_ignore_invalid", 32'(slip_seen), 32'd3);

        // Sparse enables with garbage odd/idle headers: only HSs count.
        repeat (63) blk_sparse(2'b10);
        chk("sparse_lock_63", 32'(block_lock), 32'd0);
        step(1'b1, 1'b1, 2'b10, $urandom);
        chk("sparse_lock_64", 32'(block_lock), 32'd1);
        chk("sparse_no_slip", 32'(slip_seen), 32'd3);
        step(1'b1, 1'b0, 2'b00, $urandom);
        chk("sparse_dout_en_on", 32'(dout_en), 32'd1);
        step(1'b0, 1'b1, 2'b00, $urandom);
        chk("sparse_dout_en_idle", 32'(dout_en), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
